// File: rtl/bus_guard_pkg.sv
// Shared definitions for the wishbone-8 bus guard: FSM encoding,
// config register offsets and STATUS bit positions.
package bus_guard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ABORT = 2'd2
   } guard_state_e;

   localparam logic [2:0] REG_FADR0  = 3'd0;
   localparam logic [2:0] REG_FADR1  = 3'd1;
   localparam logic [2:0] REG_FADR2  = 3'd2;
   localparam logic [2:0] REG_FADR3  = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;

   localparam int STS_FAULT     = 0;
   localparam int STS_WAS_WRITE = 1;
   localparam int STS_OVERRUN   = 2;

   localparam int CNT_W = 10;

   // Read-back view of the 3 live STATUS bits as a full register byte.
   function automatic logic [7:0] status_byte(input logic [2:0] sts);
      return {5'b0, sts};
   endfunction

endpackage

// File: rtl/bus_guard_timer.sv
// Wait-state counter for the bus guard. clear has priority over enable;
// expired flags the cycle in which the count equals LIMIT.
module bus_guard_timer
   import bus_guard_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             expired
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

   logic [CNT_W-1:0] count_q, count_d;

   // Next count: clear wins, otherwise step by one while enabled.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count   = count_q;
   assign expired = (count_q == LIMIT_C);

endmodule

// File: rtl/bus_guard_wb8.sv
// Wishbone-8 bus guard: passes CPU requests to the address decoder and
// aborts any transfer that waits TIMEOUT cycles without ack, returning
// ERRDATA and logging the faulting address in a small register file.
// Optional feature macro: BUS_GUARD_IRQ_EN (registered fault interrupt).
//
//   state | meaning
//   IDLE  | no transfer outstanding; zero-wait transfers complete here
//   WAIT  | stb seen without ack, counting wait cycles
//   ABORT | one-cycle error completion towards the CPU
module bus_guard_wb8
   import bus_guard_pkg::*;
#(
   parameter int         TIMEOUT = 255,
   parameter logic [7:0] ERRDATA = 8'hFF
) (
   input  logic        I_wb_clk,
   input  logic        I_reset_n,
   input  logic [31:0] I_m_adr,
   input  logic [7:0]  I_m_dat,
   input  logic        I_m_stb,
   input  logic        I_m_we,
   output logic [7:0]  O_m_dat,
   output logic        O_m_ack,
   output logic        O_m_stall,
   output logic        O_s_stb,
   input  logic        I_s_ack,
   input  logic [7:0]  I_s_dat,
   input  logic        I_s_stall,
   input  logic        I_cfg_stb,
   input  logic [2:0]  I_cfg_adr,
   input  logic [7:0]  I_cfg_dat,
   input  logic        I_cfg_we,
   output logic [7:0]  O_cfg_dat,
   output logic        O_cfg_ack,
   output logic        O_interrupt
);

   guard_state_e     state_q, state_d;
   logic             tmr_en, tmr_clr, tmr_expired;
   logic [CNT_W-1:0] tmr_count;
   logic             abort_start;

   logic [31:0]      fadr_q, fadr_d;
   logic [2:0]       sts_q, sts_d;
   logic             cfg_ack_q, cfg_ack_d;
   logic [7:0]       cfg_dat_q, cfg_dat_d;
   logic             sts_clr;

   // Master write data and the upper STATUS write bits have no effect here;
   // the decoder taps the master data bus directly.
   logic             unused_inputs;
   assign unused_inputs = ^{I_m_dat, I_cfg_dat[7:1], tmr_count};

   // The counter only advances on cycles that enter or remain in WAIT,
   // so it reads 0 whenever the FSM is in IDLE or ABORT.
   assign tmr_clr = !tmr_en;

   bus_guard_timer #(
      .LIMIT (TIMEOUT)
   ) u_timer (
      .clk_sys (I_wb_clk),
      .rst_b   (I_reset_n),
      .clear   (tmr_clr),
      .enable  (tmr_en),
      .count   (tmr_count),
      .expired (tmr_expired)
   );

   // FSM next state and CPU-facing outputs (pass-through except in ABORT).
   always_comb begin
      state_d     = state_q;
      O_s_stb     = I_m_stb;
      O_m_ack     = I_s_ack;
      O_m_dat     = I_s_dat;
      O_m_stall   = I_s_stall;
      tmr_en      = 1'b0;
      abort_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (I_m_stb && !I_s_ack) begin
               state_d = ST_WAIT;
               tmr_en  = 1'b1;
            end
         end
         ST_WAIT: begin
            // A genuine ack beats a simultaneous timeout.
            if (I_s_ack || !I_m_stb) begin
               state_d = ST_IDLE;
            end else if (tmr_expired) begin
               state_d     = ST_ABORT;
               abort_start = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_ABORT: begin
            O_s_stb   = 1'b0;
            O_m_stall = 1'b0;
            O_m_ack   = 1'b1;
            O_m_dat   = ERRDATA;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Fault logging and config port. A STATUS clear is applied before a
   // same-cycle abort is logged, so the new fault is captured as a first
   // fault. Writes act once per cfg access (on the cycle before ack).
   always_comb begin
      fadr_d    = fadr_q;
      sts_d     = sts_q;
      sts_clr   = I_cfg_stb && I_cfg_we && !cfg_ack_q &&
                  (I_cfg_adr == REG_STATUS) && I_cfg_dat[STS_FAULT];
      if (sts_clr) begin
         sts_d = '0;
      end
      if (abort_start) begin
         if (!sts_d[STS_FAULT]) begin
            fadr_d                 = I_m_adr;
            sts_d[STS_FAULT]       = 1'b1;
            sts_d[STS_WAS_WRITE]   = I_m_we;
            sts_d[STS_OVERRUN]     = 1'b0;
         end else begin
            sts_d[STS_OVERRUN] = 1'b1;
         end
      end

      cfg_ack_d = I_cfg_stb;
      case (I_cfg_adr)
         REG_FADR0:  cfg_dat_d = fadr_q[7:0];
         REG_FADR1:  cfg_dat_d = fadr_q[15:8];
         REG_FADR2:  cfg_dat_d = fadr_q[23:16];
         REG_FADR3:  cfg_dat_d = fadr_q[31:24];
         REG_STATUS: cfg_dat_d = status_byte(sts_q);
         default:    cfg_dat_d = 8'h00;
      endcase
   end

   // Fault registers and registered config response.
   always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         fadr_q    <= '0;
         sts_q     <= '0;
         cfg_ack_q <= 1'b0;
         cfg_dat_q <= '0;
      end else begin
         fadr_q    <= fadr_d;
         sts_q     <= sts_d;
         cfg_ack_q <= cfg_ack_d;
         cfg_dat_q <= cfg_dat_d;
      end
   end

   assign O_cfg_ack = cfg_ack_q;
   assign O_cfg_dat = cfg_dat_q;

`ifdef BUS_GUARD_IRQ_EN
   logic irq_q, irq_d;

   assign irq_d = sts_q[STS_FAULT];

   // Interrupt is a registered copy of the fault flag.
   always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign O_interrupt = irq_q;
`else
   assign O_interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_bus_guard_wb8.sv
// Directed bench for bus_guard_wb8 with TIMEOUT=8. Inputs change on the
// falling edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_bus_guard_wb8;

`ifdef BUS_GUARD_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] m_adr;
   logic [7:0]  m_dat;
   logic        m_stb, m_we;
   logic [7:0]  o_m_dat;
   logic        o_m_ack, o_m_stall, o_s_stb;
   logic        s_ack, s_stall;
   logic [7:0]  s_dat;
   logic        cfg_stb, cfg_we;
   logic [2:0]  cfg_adr;
   logic [7:0]  cfg_dat, o_cfg_dat;
   logic        o_cfg_ack, o_irq;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bus_guard_wb8 #(
      .TIMEOUT (8),
      .ERRDATA (8'hFF)
   ) dut (
      .I_wb_clk    (clk),
      .I_reset_n   (rst_n),
      .I_m_adr     (m_adr),
      .I_m_dat     (m_dat),
      .I_m_stb     (m_stb),
      .I_m_we      (m_we),
      .O_m_dat     (o_m_dat),
      .O_m_ack     (o_m_ack),
      .O_m_stall   (o_m_stall),
      .O_s_stb     (o_s_stb),
      .I_s_ack     (s_ack),
      .I_s_dat     (s_dat),
      .I_s_stall   (s_stall),
      .I_cfg_stb   (cfg_stb),
      .I_cfg_adr   (cfg_adr),
      .I_cfg_dat   (cfg_dat),
      .I_cfg_we    (cfg_we),
      .O_cfg_dat   (o_cfg_dat),
      .O_cfg_ack   (o_cfg_ack),
      .O_interrupt (o_irq)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic cfg_rd(input logic [2:0] adr, output logic [7:0] dat);
      @(negedge clk);
      cfg_stb = 1'b1; cfg_we = 1'b0; cfg_adr = adr;
      @(negedge clk);
      check_val("cfg_ack", 32'(o_cfg_ack), 32'h1);
      dat = o_cfg_dat;
      cfg_stb = 1'b0;
   endtask

   task automatic cfg_wr(input logic [2:0] adr, input logic [7:0] dat);
      @(negedge clk);
      cfg_stb = 1'b1; cfg_we = 1'b1; cfg_adr = adr; cfg_dat = dat;
      @(negedge clk);
      cfg_stb = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic rd_fadr(output logic [31:0] fadr);
      logic [7:0] b;
      fadr = '0;
      for (int k = 0; k < 4; k++) begin
         cfg_rd(3'(k), b);
         fadr[k*8 +: 8] = b;
      end
   endtask

   task automatic rd_status(output logic [7:0] sts);
      cfg_rd(3'd4, sts);
   endtask

   // One master transfer. Index i counts falling edges from the first stb
   // cycle (i=0). ack_at/drop_at/clr_at < 0 disables that event. cyc is the
   // index at which O_m_ack was seen, -1 if never within the window.
   task automatic xfer(input logic [31:0] adr, input logic we, input int ack_at,
                       input int drop_at, input int clr_at,
                       output int cyc, output logic [7:0] dat, output logic sstb);
      cyc = -1; dat = '0; sstb = 1'b0;
      for (int i = 0; i <= 20; i++) begin
         @(negedge clk);
         m_adr = adr; m_we = we;
         m_stb = (drop_at < 0) || (i < drop_at);
         s_ack = (i == ack_at);
         s_dat = 8'hA5;
         s_stall = 1'b1;
         if (i == clr_at) begin
            cfg_stb = 1'b1; cfg_we = 1'b1; cfg_adr = 3'd4; cfg_dat = 8'h01;
         end else begin
            cfg_stb = 1'b0; cfg_we = 1'b0;
         end
         #1;
         if (o_m_ack) begin
            cyc = i; dat = o_m_dat; sstb = o_s_stb;
            break;
         end
      end
      m_stb = 1'b0; s_ack = 1'b0; s_stall = 1'b0; cfg_stb = 1'b0; cfg_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc;
      logic [7:0]  d, sts;
      logic [31:0] fadr;
      logic        sstb;
      int          acks;

      // Reset state and pass-through during reset.
      rst_n = 1'b0; m_adr = '0; m_dat = 8'h00; m_we = 1'b0;
      m_stb = 1'b1; s_ack = 1'b1; s_dat = 8'h5A; s_stall = 1'b1;
      cfg_stb = 1'b0; cfg_we = 1'b0; cfg_adr = '0; cfg_dat = '0;
      #12;
      check_val("rst_s_stb",   32'(o_s_stb),   32'h1);
      check_val("rst_m_ack",   32'(o_m_ack),   32'h1);
      check_val("rst_m_dat",   32'(o_m_dat),   32'h5A);
      check_val("rst_m_stall", 32'(o_m_stall), 32'h1);
      check_val("rst_cfg_ack", 32'(o_cfg_ack), 32'h0);
      check_val("rst_irq",     32'(o_irq),     32'h0);
      m_stb = 1'b0; s_ack = 1'b0; s_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rd_status(sts);
      check_val("rst_status", 32'(sts), 32'h00);
      rd_fadr(fadr);
      check_val("rst_fadr", fadr, 32'h0);

      // Acked read after 3 wait cycles.
      xfer(32'h0000_1000, 1'b0, 3, -1, -1, cyc, d, sstb);
      check_val("ack3_cycle", 32'(cyc), 32'd3);
      check_val("ack3_data",  32'(d),   32'hA5);
      check_val("ack3_s_stb", 32'(sstb), 32'h1);
      // Zero-wait transfer.
      xfer(32'h0000_1001, 1'b0, 0, -1, -1, cyc, d, sstb);
      check_val("ack0_cycle", 32'(cyc), 32'd0);
      rd_status(sts);
      check_val("ack_status", 32'(sts), 32'h00);

      // First timeout on a read.
      xfer(32'h1234_5678, 1'b0, -1, -1, -1, cyc, d, sstb);
      check_val("to1_cycle", 32'(cyc), 32'd9);
      check_val("to1_data",  32'(d),   32'hFF);
      check_val("to1_s_stb", 32'(sstb), 32'h0);
      rd_fadr(fadr);
      check_val("to1_fadr", fadr, 32'h1234_5678);
      rd_status(sts);
      check_val("to1_status", 32'(sts), 32'h01);
      check_val("to1_irq", 32'(o_irq), 32'(IRQ_ON));

      // Second timeout (write) without clear: overrun, FADR kept.
      xfer(32'hAABB_CCDD, 1'b1, -1, -1, -1, cyc, d, sstb);
      check_val("to2_cycle", 32'(cyc), 32'd9);
      rd_fadr(fadr);
      check_val("to2_fadr", fadr, 32'h1234_5678);
      rd_status(sts);
      check_val("to2_status", 32'(sts), 32'h05);

      // Writes without bit0 and writes to FADR are ignored; bit0 clears.
      cfg_wr(3'd4, 8'h06);
      rd_status(sts);
      check_val("nclr_status", 32'(sts), 32'h05);
      cfg_wr(3'd0, 8'h00);
      cfg_rd(3'd0, d);
      check_val("fadr_ro", 32'(d), 32'h78);
      cfg_rd(3'd6, d);
      check_val("reg6_zero", 32'(d), 32'h00);
      cfg_wr(3'd4, 8'h01);
      rd_status(sts);
      check_val("clr_status", 32'(sts), 32'h00);
      check_val("clr_irq", 32'(o_irq), 32'h0);

      // Ack exactly at count == TIMEOUT wins.
      xfer(32'h0000_2000, 1'b0, 8, -1, -1, cyc, d, sstb);
      check_val("edge_cycle", 32'(cyc), 32'd8);
      check_val("edge_data",  32'(d),   32'hA5);
      // Master withdrawal mid-wait: no ack, no fault.
      xfer(32'h0000_3000, 1'b0, -1, 4, -1, cyc, d, sstb);
      check_val("wdraw_cycle", 32'(cyc), 32'hFFFF_FFFF);
      rd_status(sts);
      check_val("edge_status", 32'(sts), 32'h00);

      // Fault on a write, then clear colliding with a new read abort.
      xfer(32'h1111_0000, 1'b1, -1, -1, -1, cyc, d, sstb);
      rd_status(sts);
      check_val("wr_status", 32'(sts), 32'h03);
      xfer(32'hCAFE_0001, 1'b0, -1, -1, 8, cyc, d, sstb);
      check_val("coll_cycle", 32'(cyc), 32'd9);
      rd_status(sts);
      check_val("coll_status", 32'(sts), 32'h01);
      rd_fadr(fadr);
      check_val("coll_fadr", fadr, 32'hCAFE_0001);

      // Reset pulse in WAIT at count 5 drops the transfer.
      acks = 0;
      for (int i = 0; i <= 5; i++) begin
         @(negedge clk);
         m_adr = 32'h5555_0000; m_we = 1'b0; m_stb = 1'b1; s_ack = 1'b0;
         #1;
         if (o_m_ack) acks++;
      end
      rst_n = 1'b0;
      #1;
      m_stb = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #1;
         if (o_m_ack) acks++;
      end
      check_val("rstw_acks", 32'(acks), 32'd0);
      check_val("rstw_irq", 32'(o_irq), 32'h0);
      rd_status(sts);
      check_val("rstw_status", 32'(sts), 32'h00);
      rd_fadr(fadr);
      check_val("rstw_fadr", fadr, 32'h0);
      // Fresh timeout after reset still takes the full TIMEOUT+1 cycles.
      xfer(32'h0BAD_0BAD, 1'b0, -1, -1, -1, cyc, d, sstb);
      check_val("rstw_to_cycle", 32'(cyc), 32'd9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_guard_wb8.md
BUS_GUARD_WB8 -- requirements
Module: bus_guard_wb8

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 255: cycles without ack before a transfer is aborted, legal range 2..1023.
REQ-002 The module SHALL have parameter ERRDATA, default 8'hFF: read data returned to the master on an aborted transfer.
REQ-003 Port I_wb_clk  in  1  the single clock; all logic is rising-edge.
REQ-004 Port I_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 Ports I_m_adr in 32, I_m_dat in 8, I_m_stb in 1, I_m_we in 1 SHALL carry the upstream (CPU) request.
REQ-006 Ports O_m_dat out 8, O_m_ack out 1, O_m_stall out 1 SHALL carry the response to the CPU.
REQ-007 Ports O_s_stb out 1, I_s_ack in 1, I_s_dat in 8, I_s_stall in 1 SHALL connect to the downstream address decoder; adr/dat/we pass to it unmodified.
REQ-008 Ports I_cfg_stb in 1, I_cfg_adr in 3, I_cfg_dat in 8, I_cfg_we in 1, O_cfg_dat out 8, O_cfg_ack out 1 SHALL form the register slave port.
REQ-009 Port O_interrupt  out  1 SHALL be the fault interrupt.

Function
REQ-010 The FSM SHALL have states IDLE, WAIT and ABORT.
REQ-011 In IDLE and WAIT: O_s_stb=I_m_stb, O_m_ack=I_s_ack, O_m_dat=I_s_dat, O_m_stall=I_s_stall, all combinational.
REQ-012 IDLE->WAIT SHALL occur on a cycle with I_m_stb=1 and I_s_ack=0; the 10-bit counter loads 1.
REQ-013 If I_s_ack=1 in the same cycle as I_m_stb, the FSM SHALL stay in IDLE (zero-wait transfer).
REQ-014 In WAIT the counter SHALL increment every cycle, stall cycles included.
REQ-015 WAIT->IDLE SHALL occur on I_s_ack=1 or on I_m_stb=0 (master withdrawal); no fault is recorded.
REQ-016 WAIT->ABORT SHALL occur when the counter equals TIMEOUT with I_s_ack=0.
REQ-017 If I_s_ack=1 in the cycle the counter equals TIMEOUT, the genuine ack SHALL win and no fault is recorded.
REQ-018 ABORT SHALL last exactly 1 cycle with O_s_stb=0, O_m_stall=0, O_m_ack=1, O_m_dat=ERRDATA, then return to IDLE.
REQ-019 An aborted transfer SHALL therefore complete TIMEOUT+1 cycles after stb was first seen.
REQ-020 On entry to ABORT with fault flag clear: latch I_m_adr into FADR, latch I_m_we into bit1 of STATUS, set bit0 (fault).
REQ-021 On entry to ABORT with the flag already set: FADR is kept and bit2 (overrun) is set.
REQ-022 Register map: cfg_adr 0..3 = FADR bytes little-endian (RO); 4 = STATUS {5'b0, overrun, was_write, fault}; 5..7 read 0.
REQ-023 Writing STATUS with bit0=1 SHALL clear bits 0..2; other writes are ignored.
REQ-024 If a STATUS clear and a new fault occur in the same cycle, the new fault SHALL win: fault=1, overrun=0, FADR=new address.
REQ-025 O_cfg_ack SHALL be registered: 1 the cycle after I_cfg_stb, held while stb stays high, with O_cfg_dat valid alongside it.

Reset
REQ-026 I_reset_n=0 SHALL immediately force IDLE, counter=0, FADR=0, STATUS=0, O_cfg_ack=0, O_interrupt=0.
REQ-027 Reset mid-WAIT or mid-ABORT SHALL drop the transfer without a fault being recorded.
REQ-028 Pass-through outputs SHALL follow the upstream inputs per REQ-011 during reset.

Configuration
REQ-029 With macro BUS_GUARD_IRQ_EN defined, O_interrupt SHALL be a registered copy of STATUS.fault.
REQ-030 Without BUS_GUARD_IRQ_EN, O_interrupt SHALL be constant 0 and all other behaviour is unchanged.

Structure
REQ-031 A shared package bus_guard_pkg SHALL hold the FSM state encoding, the register offsets (FADR0..3=0..3, STATUS=4) and the STATUS bit indices.
REQ-032 The counter plus compare SHALL live in one sub-module, bus_guard_timer, with ports clear, enable, count and expired.

Verification
REQ-033 Read with downstream ack after 3 cycles -> O_m_ack in the same cycle as I_s_ack, data passed through, STATUS=0.
REQ-034 TIMEOUT=8, never ack, adr 0x12345678 read -> O_m_ack with 0xFF 9 cycles after stb; FADR=0x12345678; STATUS=0x01; O_interrupt=1 (IRQ_EN).
REQ-035 Second timeout, write to 0xAABBCCDD, without clear -> FADR stays 0x12345678; STATUS=0x05.
REQ-036 TIMEOUT=8, I_s_ack asserted exactly at count 8 -> genuine data returned, no fault.
REQ-037 STATUS clear written in the same cycle as a new abort -> STATUS=0x01, FADR holds the new address.
REQ-038 I_reset_n pulsed low in WAIT at count 5 -> FSM in IDLE, no ack issued, STATUS=0.
